// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM write controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECHARGE,
        DRIVE,
        WORDLINE,
        RECOVER
    } state_t;

    localparam int CNT_W       = 4;
    localparam int DEF_PRE_CYC = 2;
    localparam int DEF_WL_CYC  = 3;

endpackage

// File: rtl/sram_write_ctrl_row_decoder.sv
// One-hot wordline decoder; addresses at or beyond ROWS select no row.
module row_decoder #(
    parameter int ROWS = 16,
    parameter int AW   = 4
) (
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [ROWS-1:0] wl
);

    always_comb begin
        wl = '0;
        for (int i = 0; i < ROWS; i++) begin
            wl[i] = en && (addr == AW'(i));
        end
    end

endmodule

// File: rtl/sram_write_ctrl.sv
// SRAM write sequencer: precharge, drive, wordline pulse, recover; all outputs registered.
// Optional per-column write mask enabled by defining SRAM_WR_MASK_EN.
module sram_write_ctrl
    import sram_pkg::*;
#(
    parameter int COLS    = 8,
    parameter int ROWS    = 16,
    parameter int PRE_CYC = DEF_PRE_CYC,
    parameter int WL_CYC  = DEF_WL_CYC,
    localparam int AW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    // Handshake: a request transfers on a rising edge where req_valid && req_ready.
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_addr,
    input  logic [COLS-1:0] req_data,
`ifdef SRAM_WR_MASK_EN
    input  logic [COLS-1:0] req_mask,
`endif
    output logic [COLS-1:0] data_in,
    output logic [COLS-1:0] wd_en,
    output logic            pre_en,
    output logic [ROWS-1:0] wl,
    output logic            done,
    output logic            done_err,
    output state_t          dbg_state
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [COLS-1:0]   data_q, data_d;
    logic [COLS-1:0]   mask_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              pre_q, pre_d;
    logic [COLS-1:0]   wd_q, wd_d;
    logic [ROWS-1:0]   wl_q, wl_d;
    logic              done_q, done_d;
    logic              done_err_q, done_err_d;
    logic              accept;

`ifdef SRAM_WR_MASK_EN
    logic [COLS-1:0] mask_q;
`endif

    assign accept = req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef SRAM_WR_MASK_EN
        mask_d  = mask_q;
`else
        mask_d  = '1;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PRECHARGE;
                    cnt_d   = CNT_W'(PRE_CYC - 1);
                    addr_d  = req_addr;
                    data_d  = req_data;
                    err_d   = 32'(req_addr) >= ROWS;
`ifdef SRAM_WR_MASK_EN
                    mask_d  = req_mask;
`endif
                end
            end
            PRECHARGE: begin
                if (cnt_q == '0) state_d = DRIVE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DRIVE: begin
                state_d = WORDLINE;
                cnt_d   = CNT_W'(WL_CYC - 1);
            end
            WORDLINE: begin
                if (cnt_q == '0) state_d = RECOVER;
                else             cnt_d   = cnt_q - 1'b1;
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they change on the same edge as the state.
    row_decoder #(.ROWS(ROWS), .AW(AW)) u_row_decoder (
        .addr (addr_d),
        .en   (state_d == WORDLINE),
        .wl   (wl_d)
    );

    always_comb begin
        ready_d    = (state_d == IDLE);
        pre_d      = (state_d == PRECHARGE);
        wd_d       = (state_d == DRIVE || state_d == WORDLINE || state_d == RECOVER) ? mask_d : '0;
        done_d     = (state_d == RECOVER);
        done_err_d = done_d && err_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            pre_q      <= 1'b0;
            wd_q       <= '0;
            wl_q       <= '0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            pre_q      <= pre_d;
            wd_q       <= wd_d;
            wl_q       <= wl_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end

`ifdef SRAM_WR_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) mask_q <= '0;
        else     mask_q <= mask_d;
    end
`endif

    assign req_ready = ready_q;
    assign data_in   = data_q;
    assign wd_en     = wd_q;
    assign pre_en    = pre_q;
    assign wl        = wl_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Bench for sram_write_ctrl: directed scenarios plus random traffic against a timeline model.
module tb_sram_write_ctrl;
    import sram_pkg::*;

    localparam int PRE = 2;
    localparam int WLC = 3;
    localparam int LAT = PRE + WLC + 2;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic [7:0] req_mask = 8'hFF;

    logic        req_ready, pre_en, done, done_err;
    logic [7:0]  data_in, wd_en;
    logic [15:0] wl;
    state_t      dbg_state;

    logic        r12_ready, r12_pre, r12_done, r12_err;
    logic [7:0]  r12_data, r12_wd;
    logic [11:0] r12_wl;
    state_t      r12_state;

    sram_write_ctrl #(.COLS(8), .ROWS(16), .PRE_CYC(PRE), .WL_CYC(WLC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
`ifdef SRAM_WR_MASK_EN
        .req_mask(req_mask),
`endif
        .data_in(data_in), .wd_en(wd_en), .pre_en(pre_en), .wl(wl),
        .done(done), .done_err(done_err), .dbg_state(dbg_state)
    );

    sram_write_ctrl #(.COLS(8), .ROWS(12), .PRE_CYC(PRE), .WL_CYC(WLC)) dut12 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r12_ready),
        .req_addr(req_addr), .req_data(req_data),
`ifdef SRAM_WR_MASK_EN
        .req_mask(req_mask),
`endif
        .data_in(r12_data), .wd_en(r12_wd), .pre_en(r12_pre), .wl(r12_wl),
        .done(r12_done), .done_err(r12_err), .dbg_state(r12_state)
    );

    always @(negedge clk) begin
        assert (!(pre_en && (|wd_en || |wl)));
        assert ($onehot0(wl));
        assert (!(r12_pre && (|r12_wd || |r12_wl)));
        assert ($onehot0(r12_wl));
    end

    // scoreboard
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: t counts cycles since the accepting edge (1..LAT while busy).
    bit         busy = 0;
    int         t = 0;
    bit         ready_e = 0;
    logic [7:0] data_e = '0;
    logic [3:0] addr_e = '0;
    logic [7:0] mask_e = 8'hFF;

    task automatic model_step();
        if (rst) begin
            busy = 0; ready_e = 0; data_e = '0;
        end else if (busy) begin
            t++;
            if (t > LAT) begin
                busy = 0; ready_e = 1;
            end
        end else if (ready_e && req_valid) begin
            busy = 1; t = 1; data_e = req_data; addr_e = req_addr;
`ifdef SRAM_WR_MASK_EN
            mask_e = req_mask;
`else
            mask_e = 8'hFF;
`endif
            ready_e = 0;
        end else begin
            ready_e = 1;
        end
    endtask

    function automatic logic [15:0] exp_wl(input int rows);
        if (busy && t >= PRE + 2 && t <= PRE + WLC + 1 && int'(addr_e) < rows)
            return 16'(1) << addr_e;
        return '0;
    endfunction

    task automatic check_outputs();
        logic       e_pre, e_done;
        logic [7:0] e_wd;
        e_pre  = busy && t <= PRE;
        e_done = busy && t == LAT;
        e_wd   = (busy && t > PRE) ? mask_e : 8'h00;
        chk("ready",    32'(req_ready), 32'(ready_e));
        chk("data_in",  32'(data_in),   32'(data_e));
        chk("pre_en",   32'(pre_en),    32'(e_pre));
        chk("wd_en",    32'(wd_en),     32'(e_wd));
        chk("wl",       32'(wl),        32'(exp_wl(16)));
        chk("done",     32'(done),      32'(e_done));
        chk("done_err", 32'(done_err),  32'(e_done && addr_e >= 16));
        chk("idle",     32'(dbg_state == IDLE), 32'(!busy));
        chk("r12_ready",    32'(r12_ready), 32'(ready_e));
        chk("r12_data_in",  32'(r12_data),  32'(data_e));
        chk("r12_pre_en",   32'(r12_pre),   32'(e_pre));
        chk("r12_wd_en",    32'(r12_wd),    32'(e_wd));
        chk("r12_wl",       32'(r12_wl),    32'(exp_wl(12)));
        chk("r12_done",     32'(r12_done),  32'(e_done));
        chk("r12_done_err", 32'(r12_err),   32'(e_done && addr_e >= 12));
    endtask

    // driver: check the current cycle, drive inputs for the next edge, advance the model
    task automatic cyc(input logic r, input logic v, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] m);
        @(negedge clk);
        check_outputs();
        rst = r; req_valid = v; req_addr = a; req_data = d; req_mask = m;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        @(posedge clk);
        model_step();
        cyc(1'b1, 1'b0, 4'd0, 8'h00, 8'hFF);
        idle_cycles(2);

        // single write, addr 5 / 8'hA5
        cyc(1'b0, 1'b1, 4'd5, 8'hA5, 8'hFF);
        idle_cycles(LAT + 2);

        // valid held high: later requests wait for the sequence to finish
        for (int i = 0; i < 3 * (LAT + 1); i++)
            cyc(1'b0, 1'b1, 4'($urandom_range(0, 15)), 8'($urandom), 8'hFF);
        idle_cycles(LAT + 2);

        // out-of-range for the 12-row instance, boundary row for the 16-row one
        cyc(1'b0, 1'b1, 4'd15, 8'h5A, 8'hFF);
        idle_cycles(LAT + 2);
        cyc(1'b0, 1'b1, 4'd11, 8'hC3, 8'hFF);
        idle_cycles(LAT + 2);

        // reset during cycle 5 of a write
        cyc(1'b0, 1'b1, 4'd7, 8'h96, 8'hFF);
        idle_cycles(4);
        cyc(1'b1, 1'b0, 4'd0, 8'h00, 8'hFF);
        idle_cycles(LAT + 2);

`ifdef SRAM_WR_MASK_EN
        cyc(1'b0, 1'b1, 4'd3, 8'h3C, 8'h0F);
        idle_cycles(LAT + 2);
`endif

        // random traffic
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0),
                4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));

        @(negedge clk);
        check_outputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_write_ctrl.md
SRAM_WRITE_CTRL -- requirements
Module: sram_write_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 8, meaning data word width and number of bitline pairs.
REQ-002 SHALL have parameter ROWS, default 16, meaning number of wordlines.
REQ-003 SHALL have parameter PRE_CYC, default 2, meaning precharge duration in cycles (legal range 1..15).
REQ-004 SHALL have parameter WL_CYC, default 3, meaning wordline pulse width in cycles (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit: a write request is present.
REQ-008 SHALL have port req_ready, output, 1 bit: the controller can accept a request.
REQ-009 SHALL have port req_addr, input, $clog2(ROWS) bits: the target row.
REQ-010 SHALL have port req_data, input, COLS bits: the word to write.
REQ-011 SHALL have port data_in, output, COLS bits: the word fed to the write driver data input.
REQ-012 SHALL have port wd_en, output, COLS bits: per-column write-driver bitline connect enable.
REQ-013 SHALL have port pre_en, output, 1 bit: bitline precharge enable.
REQ-014 SHALL have port wl, output, ROWS bits: one-hot wordline.
REQ-015 SHALL have port done, output, 1 bit: one-cycle write-complete pulse.
REQ-016 SHALL have port done_err, output, 1 bit: qualifies done; high when the address was out of range.

Function
REQ-017 SHALL implement the states IDLE, PRECHARGE, DRIVE, WORDLINE and RECOVER, with every output registered.
REQ-018 SHALL drive req_ready=1 only in IDLE; a request is accepted on any edge where req_valid && req_ready.
REQ-019 SHALL, on accept, capture req_addr and req_data and move to PRECHARGE; data_in holds the captured word until the next accept.
REQ-020 SHALL drive pre_en=1 for exactly PRE_CYC cycles in PRECHARGE, then move to DRIVE.
REQ-021 SHALL spend 1 cycle in DRIVE with wd_en active, wl=0 and pre_en=0, so bitlines settle before the wordline rises.
REQ-022 SHALL spend exactly WL_CYC cycles in WORDLINE with wd_en active and wl one-hot at the captured address.
REQ-023 SHALL spend 1 cycle in RECOVER with wl=0 and wd_en active, assert done in that cycle, then return to IDLE.
REQ-024 SHALL give fixed latency: accepted at edge T0, done high in cycle T0+PRE_CYC+WL_CYC+2, req_ready high again one cycle later; with the default parameters done is at cycle 7 and req_ready at cycle 8.
REQ-025 SHALL, for req_addr >= ROWS, run the full sequence with wl held at 0 and assert done_err together with done.
REQ-026 SHALL never assert pre_en and any wd_en bit in the same cycle, and never assert pre_en while any wl bit is high.
REQ-027 SHALL ignore req_valid and req_data changes outside IDLE, with no queuing.
REQ-028 SHALL implement phase counters as 4-bit down-counters, loaded on state entry, that advance the state at zero.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, req_ready=0, data_in=0, wd_en=0, pre_en=0, wl=0, done=0 and done_err=0.
REQ-030 SHALL drive req_ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL, on reset mid-operation, drop wl and wd_en the next cycle and not assert done for the aborted write.

Configuration
REQ-032 SHALL, when SRAM_WR_MASK_EN is defined, add input req_mask (COLS bits, captured on accept); wd_en[i] is active only where the captured mask bit is 1.
REQ-033 SHALL, when SRAM_WR_MASK_EN is undefined, have no req_mask port, and all wd_en bits SHALL be 1 whenever wd_en is active.

Structure
REQ-034 SHALL place the state enum, the counter width and the default PRE_CYC/WL_CYC constants in shared package sram_pkg.
REQ-035 SHALL instantiate one sub-module, row_decoder, which maps (addr, en) to a one-hot wl and gives all-zero output for addr >= ROWS.

Verification
REQ-036 SHALL cover a single write of addr=5, data=8'hA5: pre_en high in cycles 1-2, wd_en=8'hFF in cycles 3-7, wl=16'h0020 in cycles 4-6, done in cycle 7, req_ready in cycle 8.
REQ-037 SHALL cover back-to-back requests with req_valid held high: the second is accepted only at cycle 8, and data_in changes only at that accept.
REQ-038 SHALL cover a write to addr=15 with ROWS=12: wl=0 throughout, done and done_err both high in cycle T0+PRE_CYC+WL_CYC+2.
REQ-039 SHALL cover rst asserted in cycle 5 of a write: wl=0 and wd_en=0 from cycle 6, no done pulse, and req_ready high the cycle after rst deasserts.
REQ-040 SHALL cover, with SRAM_WR_MASK_EN defined, a write of mask=8'h0F, data=8'h3C: wd_en=8'h0F in DRIVE/WORDLINE/RECOVER and data_in=8'h3C.
REQ-041 SHALL check, every cycle as an assertion, that pre_en && (|wd_en || |wl) is never true and that $onehot0(wl) always holds.
